// File: rtl/ucaspian_synapse.sv
// Synapse range walker: reads the synapse RAM over [syn_start, syn_end] and emits {target, weight} events.
// Optional build macro UCASPIAN_SYN_SKIP_ZERO_EN suppresses events for zero-weight entries.
module ucaspian_synapse #(
  parameter int SYN_DEPTH      = 4096,
  parameter int OUT_FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_act,
  input  logic              clear_config,
  output logic              clear_done,
  input  logic [11:0]       config_addr,
  input  logic [11:0]       config_value,
  input  logic [2:0]        config_byte,
  input  logic              config_enable,
  input  logic              next_step,
  output logic              step_done,
  input  logic [11:0]       syn_start,
  input  logic [11:0]       syn_end,
  input  logic              syn_vld,
  output logic              syn_rdy,
  output logic [7:0]        dend_addr,
  output logic signed [7:0] dend_weight,
  output logic              dend_vld,
  input  logic              dend_rdy
);
  localparam int AW     = 12;
  localparam int DATA_W = 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(SYN_DEPTH - 1);
  localparam logic [1:0]    CREDITS   = 2'(OUT_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;
  state_t state, state_nxt;

  logic [2*DATA_W-1:0] mem [SYN_DEPTH];
  logic [DATA_W-1:0]   staging;
  logic [AW-1:0]       cur_p0, last_p0, clr_addr;
  logic                sweep_done, rdy_q;
  logic                flush, accept, rd_en_p0, pop, push_p1, cfg_ok, wr_en;
  logic [AW-1:0]       wr_addr;
  logic [2*DATA_W-1:0] wr_data;
  logic                rd_vld_p1;
  logic [2*DATA_W-1:0] rd_data_p1;
  logic [1:0]          fifo_count, credit_used;
  logic [2*DATA_W-1:0] fifo_q0, fifo_q1;
  logic                unused_cfg;

  assign unused_cfg = ^config_value[11:8];
  assign flush      = clear_config || clear_act;
  assign syn_rdy    = rdy_q && !flush;
  assign accept     = (state == IDLE) && syn_vld && syn_rdy;
  assign pop        = dend_vld && dend_rdy;

  // A slot being popped this cycle is already free, which keeps one event per cycle.
  assign credit_used = fifo_count + {1'b0, rd_vld_p1} - {1'b0, pop};
  assign rd_en_p0    = (state == RUN) && enable && !flush && (credit_used < CREDITS);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (rd_en_p0 && (cur_p0 == last_p0)) state_nxt = IDLE;
      CLEAR:   if (!clear_config) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_config)   state_nxt = CLEAR;
    else if (clear_act) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cur_p0  <= syn_start;
      last_p0 <= syn_end;
    end else if (rd_en_p0) begin
      cur_p0 <= cur_p0 + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state != CLEAR) begin
      clr_addr   <= '0;
      sweep_done <= 1'b0;
    end else begin
      if (clr_addr != LAST_ADDR) clr_addr <= clr_addr + 12'd1;
      if (clr_addr == LAST_ADDR) sweep_done <= 1'b1;
    end
  end

  // Configuration staging and the single RAM write port (sweep wins over config)
  assign cfg_ok  = config_enable && !reset && !flush && (state != CLEAR);
  assign wr_en   = (state == CLEAR) || (cfg_ok && config_byte == 3'd3);
  assign wr_addr = (state == CLEAR) ? clr_addr : config_addr;
  assign wr_data = (state == CLEAR) ? '0 : {staging, config_value[7:0]};

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      case (config_byte)
        3'd1:    staging <= '0;
        3'd2:    staging <= config_value[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // p0 -> p1: synchronous RAM read, old data on a same-cycle write
  always_ff @(posedge clk) begin
    if (rd_en_p0) rd_data_p1 <= mem[cur_p0];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) rd_vld_p1 <= 1'b0;
    else                rd_vld_p1 <= rd_en_p0;
  end

`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
  assign push_p1 = rd_vld_p1 && (rd_data_p1[15:8] != '0);
`else
  assign push_p1 = rd_vld_p1;
`endif

  // p1 -> output: two-entry skid FIFO, head in fifo_q0
  always_ff @(posedge clk) begin
    if (reset || flush) fifo_count <= '0;
    else                fifo_count <= fifo_count + {1'b0, push_p1} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      if (push_p1 && fifo_count == 2'd1) fifo_q0 <= rd_data_p1;
      else                               fifo_q0 <= fifo_q1;
      if (push_p1 && fifo_count == 2'd2) fifo_q1 <= rd_data_p1;
    end else if (push_p1) begin
      if (fifo_count == 2'd0) fifo_q0 <= rd_data_p1;
      else                    fifo_q1 <= rd_data_p1;
    end
  end

  assign dend_vld    = (fifo_count != 2'd0);
  assign dend_addr   = dend_vld ? fifo_q0[7:0] : '0;
  assign dend_weight = dend_vld ? $signed(fifo_q0[15:8]) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_done  <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      step_done  <= !next_step && (state == IDLE) && !syn_vld &&
                    (fifo_count == 2'd0) && !rd_vld_p1;
      clear_done <= clear_config ? sweep_done : clear_act;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (reset)
    !(push_p1 && !pop && !flush && fifo_count == CREDITS));

endmodule

// File: tb/tb_ucaspian_synapse.sv
// Scoreboard bench for ucaspian_synapse: a model RAM predicts every event, a negedge monitor checks them.
module tb_ucaspian_synapse;
`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b1, clear_act = 1'b0, clear_config = 1'b0;
  logic config_enable = 1'b0, next_step = 1'b0, syn_vld = 1'b0, dend_rdy = 1'b0;
  logic [11:0] config_addr = '0, config_value = '0, syn_start = '0, syn_end = '0;
  logic [2:0]  config_byte = '0;
  logic clear_done, step_done, syn_rdy, dend_vld;
  logic [7:0] dend_addr;
  logic signed [7:0] dend_weight;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_cnt   = 0;
  logic [15:0] model_mem [4096];
  logic [15:0] exp_q [$];
  logic [15:0] prev_ev = '0;
  logic        prev_stall = 1'b0;

  always #5 clk = ~clk;

  ucaspian_synapse dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_act(clear_act),
    .clear_config(clear_config), .clear_done(clear_done),
    .config_addr(config_addr), .config_value(config_value),
    .config_byte(config_byte), .config_enable(config_enable),
    .next_step(next_step), .step_done(step_done),
    .syn_start(syn_start), .syn_end(syn_end), .syn_vld(syn_vld), .syn_rdy(syn_rdy),
    .dend_addr(dend_addr), .dend_weight(dend_weight), .dend_vld(dend_vld), .dend_rdy(dend_rdy)
  );

  // Event monitor: stability under stall and in-order scoreboard compare
  always @(negedge clk) begin
    logic quiet;
    logic [15:0] got, want;
    quiet = !reset && !clear_act && !clear_config;
    got   = {dend_weight, dend_addr};
    if (quiet && prev_stall) begin
      n_checks++;
      if (dend_vld !== 1'b1 || got !== prev_ev) begin
        n_fail++;
        $display("FAIL stall_hold: got vld=%b data=%h, required vld=1 data=%h", dend_vld, got, prev_ev);
      end
    end
    prev_stall = quiet && dend_vld && !dend_rdy;
    prev_ev    = got;
    if (quiet && dend_vld && dend_rdy) begin
      ev_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL event_unexpected: got data=%h, required no event", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL event_data #%0d: got {w,t}=%h, required %h", ev_cnt, got, want);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [7:0] w, input logic [7:0] t);
    config_enable = 1'b1;
    config_addr   = 12'(addr);
    config_byte   = 3'd1; config_value = 12'hFFF; tick();
    config_byte   = 3'd2; config_value = {4'hA, w}; tick();
    config_byte   = 3'd3; config_value = {4'h5, t}; tick();
    config_enable = 1'b0;
    config_byte   = 3'd0;
    model_mem[addr & 4095] = {w, t};
  endtask

  task automatic send_range(input logic [11:0] s, input logic [11:0] e);
    int c = 0;
    int n;
    logic [11:0] idx;
    while (syn_rdy !== 1'b1 && c < 20) begin tick(); c++; end
    n_checks++;
    if (c >= 20) begin
      n_fail++;
      $display("FAIL range_rdy: syn_rdy=%b after %0d cycles, required 1", syn_rdy, c);
    end
    syn_start = s; syn_end = e; syn_vld = 1'b1;
    tick();
    syn_vld = 1'b0;
    n = int'(12'(e - s)) + 1;
    for (int k = 0; k < n; k++) begin
      idx = s + 12'(k);
      if (!(SKIP_ZERO && model_mem[idx][15:8] == 8'h00)) exp_q.push_back(model_mem[idx]);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while (c < budget && !(exp_q.size() == 0 && step_done === 1'b1 && dend_vld === 1'b0)) begin
      tick(); c++;
    end
    n_checks++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s_drain: %0d events outstanding, step_done=%b, required 0 and 1", name, exp_q.size(), step_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if ({syn_rdy, dend_vld, dend_addr, dend_weight, step_done, clear_done} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b addr=%h w=%h sd=%b cd=%b, required all 0",
               syn_rdy, dend_vld, dend_addr, dend_weight, step_done, clear_done);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (syn_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b, required 1", syn_rdy); end
    n_checks++;
    if (step_done !== 1'b1) begin n_fail++; $display("FAIL reset_step_done: got %b, required 1", step_done); end
  endtask

  task automatic test_clear_config();
    int rise = -1;
    int base;
    clear_config = 1'b1;
    for (int c = 1; c <= 4100; c++) begin
      tick();
      if (rise < 0 && clear_done === 1'b1) rise = c;
    end
    n_checks++;
    if (rise != 4098) begin n_fail++; $display("FAIL sweep_done_time: rose at cycle %0d, required 4098", rise); end
    clear_config = 1'b0;
    tick();
    n_checks++;
    if (clear_done !== 1'b0) begin n_fail++; $display("FAIL sweep_done_drop: got %b, required 0", clear_done); end
    for (int i = 0; i < 4096; i++) model_mem[i] = '0;
    dend_rdy = 1'b1;
    base = ev_cnt;
    send_range(12'd0, 12'd4095);
    wait_drain(6000, "sweep_range");
    n_checks++;
    if (ev_cnt - base != (SKIP_ZERO ? 0 : 4096)) begin
      n_fail++;
      $display("FAIL sweep_range_count: got %0d events, required %0d", ev_cnt - base, SKIP_ZERO ? 0 : 4096);
    end
  endtask

  task automatic test_next_step();
    next_step = 1'b1;
    tick();
    next_step = 1'b0;
    n_checks++;
    if (step_done !== 1'b0) begin n_fail++; $display("FAIL next_step_low: got %b, required 0", step_done); end
    tick();
    n_checks++;
    if (step_done !== 1'b1) begin n_fail++; $display("FAIL next_step_recover: got %b, required 1", step_done); end
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 256; i++) cfg_write(i, 8'(i) | 8'h01, 8'(i) ^ 8'h5A);
  endtask

  task automatic test_basic();
    cfg_write(10, 8'h05, 8'h21);
    cfg_write(11, 8'hFB, 8'h22);
    dend_rdy = 1'b1;
    send_range(12'd10, 12'd11);
    tick();
    n_checks++;
    if (dend_vld !== 1'b0) begin n_fail++; $display("FAIL basic_latency: vld=%b one cycle after accept, required 0", dend_vld); end
    tick();
    n_checks++;
    if ({dend_vld, dend_addr, dend_weight} !== {1'b1, 8'h21, 8'h05}) begin
      n_fail++;
      $display("FAIL basic_first: got vld=%b addr=%h w=%h, required 1 21 05", dend_vld, dend_addr, dend_weight);
    end
    tick();
    n_checks++;
    if ({dend_vld, dend_addr, dend_weight} !== {1'b1, 8'h22, 8'hFB}) begin
      n_fail++;
      $display("FAIL basic_second: got vld=%b addr=%h w=%h, required 1 22 fb", dend_vld, dend_addr, dend_weight);
    end
    tick();
    n_checks++;
    if (dend_vld !== 1'b0) begin n_fail++; $display("FAIL basic_end: vld=%b, required 0", dend_vld); end
    wait_drain(20, "basic");
  endtask

  task automatic test_wrap();
    int base;
    cfg_write(4094, 8'h11, 8'h01);
    cfg_write(4095, 8'h12, 8'h02);
    cfg_write(0, 8'h93, 8'h03);
    cfg_write(1, 8'h14, 8'h04);
    base = ev_cnt;
    send_range(12'd4094, 12'd1);
    wait_drain(40, "wrap");
    n_checks++;
    if (ev_cnt - base != 4) begin n_fail++; $display("FAIL wrap_count: got %0d events, required 4", ev_cnt - base); end
  endtask

  task automatic test_enable();
    int base = ev_cnt;
    int seen = 0;
    enable = 1'b0;
    send_range(12'd20, 12'd23);
    for (int c = 0; c < 5; c++) begin tick(); if (dend_vld !== 1'b0) seen++; end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL enable_hold: vld high %0d cycles with enable low, required 0", seen); end
    enable = 1'b1;
    wait_drain(40, "enable");
    n_checks++;
    if (ev_cnt - base != 4) begin n_fail++; $display("FAIL enable_count: got %0d events, required 4", ev_cnt - base); end
  endtask

  task automatic test_stall();
    int base = ev_cnt;
    send_range(12'd0, 12'd7);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      dend_rdy = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    dend_rdy = 1'b1;
    wait_drain(40, "stall");
    n_checks++;
    if (ev_cnt - base != 8) begin n_fail++; $display("FAIL stall_count: got %0d events, required 8", ev_cnt - base); end
  endtask

  task automatic test_clear_act();
    int base = ev_cnt;
    int c = 0;
    dend_rdy = 1'b1;
    send_range(12'd0, 12'd255);
    while (ev_cnt - base < 50 && c < 1000) begin tick(); c++; end
    n_checks++;
    if (ev_cnt - base != 50) begin n_fail++; $display("FAIL clear_act_reach: got %0d events, required 50", ev_cnt - base); end
    clear_act = 1'b1;
    dend_rdy  = 1'b0;
    tick();
    n_checks++;
    if ({dend_vld, clear_done} !== 2'b01) begin
      n_fail++;
      $display("FAIL clear_act_flush: got vld=%b clear_done=%b, required 0 1", dend_vld, clear_done);
    end
    tick();
    n_checks++;
    if (clear_done !== 1'b1) begin n_fail++; $display("FAIL clear_act_hold: got %b, required 1", clear_done); end
    clear_act = 1'b0;
    exp_q.delete();
    tick();
    n_checks++;
    if ({clear_done, syn_rdy, dend_vld} !== 3'b010) begin
      n_fail++;
      $display("FAIL clear_act_release: got cd=%b rdy=%b vld=%b, required 0 1 0", clear_done, syn_rdy, dend_vld);
    end
    dend_rdy = 1'b1;
    base = ev_cnt;
    send_range(12'd3, 12'd3);
    wait_drain(20, "clear_act_single");
    n_checks++;
    if (ev_cnt - base != 1) begin n_fail++; $display("FAIL clear_act_single_count: got %0d events, required 1", ev_cnt - base); end
  endtask

  task automatic test_reset_mid();
    int base = ev_cnt;
    int c = 0;
    dend_rdy = 1'b1;
    send_range(12'd100, 12'd199);
    while (ev_cnt - base < 10 && c < 200) begin tick(); c++; end
    reset    = 1'b1;
    dend_rdy = 1'b0;
    tick();
    n_checks++;
    if ({syn_rdy, dend_vld, dend_addr, dend_weight, step_done, clear_done} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rdy=%b vld=%b addr=%h w=%h sd=%b cd=%b, required all 0",
               syn_rdy, dend_vld, dend_addr, dend_weight, step_done, clear_done);
    end
    reset = 1'b0;
    exp_q.delete();
    tick();
    n_checks++;
    if (syn_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_rdy: got %b, required 1", syn_rdy); end
    dend_rdy = 1'b1;
    base = ev_cnt;
    send_range(12'd100, 12'd101);
    wait_drain(20, "reset_mid_after");
    n_checks++;
    if (ev_cnt - base != 2) begin n_fail++; $display("FAIL reset_mid_count: got %0d events, required 2", ev_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_clear_config();
    test_next_step();
    fill_ram();
    test_basic();
    test_wrap();
    test_enable();
    test_stall();
    test_clear_act();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue: %0d events never seen, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucaspian_synapse.md
Name: ucaspian_synapse

Overview:
- Receiving end of the axon->synapse range interface.
- Accepts an inclusive synapse index range [syn_start, syn_end] and walks a 4096-entry synapse RAM over that range.
- For each entry, emits one {target neuron, signed weight} event to the neuron/dendrite stage over a valid/ready handshake.
- Owns synapse configuration writes and clearing; reports step completion for time sync.

Parameters:
- SYN_DEPTH, 4096, number of synapse entries; address width is 12 bits.
- OUT_FIFO_DEPTH, 2, output skid buffer entries; only 2 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- enable  in  1  when low, no new reads are issued; state is held
- clear_act  in  1  abort in-flight range, flush outputs
- clear_config  in  1  zero the entire synapse RAM
- clear_done  out  1  clear complete (registered)
- config_addr  in  12  synapse index to configure
- config_value  in  12  configuration data
- config_byte  in  3  configuration phase
- config_enable  in  1  configuration strobe
- next_step  in  1  timestep boundary pulse
- step_done  out  1  no work pending (registered)
- syn_start  in  12  first synapse index
- syn_end  in  12  last synapse index (inclusive)
- syn_vld  in  1  range valid
- syn_rdy  out  1  range accept
- dend_addr  out  8  target neuron
- dend_weight  out  8  signed weight (two's complement)
- dend_vld  out  1  event valid
- dend_rdy  in  1  event accept

Behaviour:
- Interface rule: reset is synchronous and active-high; clock is clk.
- Reset: state=IDLE; syn_rdy=0 in the reset cycle, then 1; dend_vld=0; dend_addr=0; dend_weight=0; step_done=0; clear_done=0; FIFO empty; no outstanding read.
- RAM word format: [15:8] weight, [7:0] target. Read latency is 1 cycle, on a dual-port RAM.
- Config writes (this block owns the write port):
  - byte 1: staging word <= 0.
  - byte 2: staging[15:8] <= config_value[7:0].
  - byte 3: staging[7:0] <= config_value[7:0], and write staging to config_addr in the same cycle.
  - Other config_byte values: ignored.
- States:
  - IDLE: syn_rdy=1. On syn_vld&&syn_rdy, latch cur=syn_start and last=syn_end, go to RUN. syn_rdy drops the cycle after acceptance.
  - RUN: issue a read at cur when enable && (fifo_count + read_outstanding) < 2. If cur==last, go to IDLE after issuing; otherwise cur<=cur+1 (12-bit wrap).
  - Range length is (syn_end - syn_start) mod 4096 + 1; wrap-around 4095->0 is legal. start==end yields exactly 1 event.
  - CLEAR: entered on clear_config from any state. Sweeps addr 0..4095 writing 0, one per cycle. Holds at 4095 with sweep_done=1 while clear_config stays high; returns to IDLE when clear_config drops.
- Output path:
  - Read data enters the 2-entry FIFO one cycle after the read is issued.
  - dend_vld = FIFO non-empty; dend_addr/dend_weight come from the FIFO head.
  - A pop occurs on dend_vld&&dend_rdy. Simultaneous push and pop is legal.
  - The credit rule guarantees no overflow; overflow is an assertion failure.
- Latency: range accept at cycle N -> first read at N+1 -> dend_vld at N+2. With dend_rdy held high, throughput is 1 event/cycle.
- dend_rdy low: reads stall after the credit is consumed. Data is held stable; no events are lost or duplicated.
- clear_act (any state):
  - Next cycle: FIFO empty, outstanding read dropped, state=IDLE, dend_vld=0.
  - clear_done=1 the cycle after clear_act is sampled, held while clear_act stays high.
  - RAM is untouched.
- clear_config: clear_done = sweep_done registered. Also flushes like clear_act. Config writes are ignored during the sweep.
- Priority: reset > clear_config > clear_act > config_enable > run logic. A config write to an index being read in the same cycle returns the old data.
- next_step: no effect on an in-flight range; it is the axon's job not to pulse it mid-range. step_done is forced 0 for the cycle after next_step.
- step_done <= (state==IDLE) && ~syn_vld && FIFO empty && ~read_outstanding.

Optional Feature:
- Macro: UCASPIAN_SYN_SKIP_ZERO_EN.
- Defined: a read returning weight==0 is not pushed into the FIFO. Its credit is released and no dend_vld pulse occurs for that index.
- Undefined: all entries in the range are emitted, including zero-weight ones.

Test Plan:
- Config index 10 = {weight 0x05, target 0x21}, index 11 = {0xFB, 0x22}; range [10,11], dend_rdy=1 -> events (0x21,+5) then (0x22,-5) on consecutive cycles, first one 2 cycles after accept; step_done=1 afterwards.
- Range [4094,1] with distinct targets 1..4 -> exactly 4 events in order 4094, 4095, 0, 1.
- Range [0,7] with dend_rdy toggling 1,0,0,1... -> exactly 8 events in order, data stable while stalled, no more than 2 buffered.
- clear_act asserted mid-range [0,255] at event 50 -> dend_vld=0 next cycle; clear_done=1 the following cycle; a new range [3,3] afterwards emits the single correct event.
- clear_config held for 4100 cycles -> clear_done rises after the sweep completes; range [0,4095] then emits 4096 zero-weight events (none if UCASPIAN_SYN_SKIP_ZERO_EN is defined, with step_done=1).
- Reset asserted mid-range [100,199] -> all outputs take their reset values next cycle; syn_rdy=1 one cycle after reset deasserts.
